ws2812_rx: RTL and testbench

- Single-wire WS2812B-style NRZ receiver/repeater; the receiving end of the LED serial stream our LED driver produces.
- Decodes the first 24 bits of each frame into a GRB word and forwards all later bits downstream unchanged, like a physical LED in a chain.
- Used as an on-chip loopback checker for the LED output, and as a building block for daisy-chain emulation.

---
 rtl/ws2812_rx.sv | 110 +++++++++++
 tb/tb_ws2812_rx.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_rx.sv
// WS2812B-style NRZ receiver/repeater: decodes the first 24 bits of a frame
// into a GRB word, then forwards every later bit downstream like an LED in a chain.
module ws2812_rx #(
    parameter int CLK_SPEED    = 25_000_000,
    parameter int THRESHOLD_NS = 600,
    parameter int GLITCH_NS    = 100,
    parameter int RESET_US     = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        din_i,
    output logic        dout_o,
    output logic [23:0] grb_o,
    output logic        valid_o,
    output logic        frame_end_o
);

    localparam int THR_CYC = CLK_SPEED / 1_000_000 * THRESHOLD_NS / 1000;
    localparam int GLT_CYC = CLK_SPEED / 1_000_000 * GLITCH_NS / 1000;
    localparam int RST_CYC = CLK_SPEED / 1_000_000 * RESET_US;
    localparam int HMAX_CYC = (THR_CYC > GLT_CYC) ? THR_CYC : GLT_CYC;
    localparam int HW = $clog2(HMAX_CYC + 2);
    localparam int LW = $clog2(RST_CYC + 1);

    localparam logic [HW-1:0] H_SAT  = '1;
    localparam logic [HW-1:0] H_THR  = HW'(THR_CYC);
    localparam logic [HW-1:0] H_GLT  = HW'(GLT_CYC);
    localparam logic [LW-1:0] L_RST  = LW'(RST_CYC);
    localparam logic [LW-1:0] L_LAST = LW'(RST_CYC - 1);

    typedef enum logic {CAPTURE, FORWARD} state_t;

    state_t        state, state_n;
    logic          s1, s2, s2_d;
    logic [HW-1:0] hcnt;
    logic [LW-1:0] lcnt;
    logic [4:0]    bitcnt, bitcnt_n;
    logic [22:0]   shreg, shreg_n;
    logic [23:0]   grb_n;
    logic          valid_n, fe_n, dout_n;
    logic          fall, gap_done, bit_val;

    assign fall     = !s2 && s2_d;
    // lcnt is about to reach RST_CYC; saturation keeps this from repeating
    assign gap_done = !s2 && (lcnt == L_LAST);
    assign bit_val  = (hcnt >= H_THR);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CAPTURE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        grb_n    = grb_o;
        valid_n  = 1'b0;
        fe_n     = 1'b0;
        dout_n   = (state == FORWARD) ? s2 : 1'b0;
        if (gap_done) begin
            fe_n     = 1'b1;
            state_n  = CAPTURE;
            bitcnt_n = '0;
            shreg_n  = '0;
        end else if (state == CAPTURE && fall && hcnt >= H_GLT) begin
            if (bitcnt == 5'd23) begin
                grb_n    = {shreg, bit_val};
                valid_n  = 1'b1;
                state_n  = FORWARD;
                bitcnt_n = '0;
            end else begin
                shreg_n  = {shreg[21:0], bit_val};
                bitcnt_n = bitcnt + 5'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s2_d        <= 1'b0;
            hcnt        <= '0;
            lcnt        <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            grb_o       <= '0;
            valid_o     <= 1'b0;
            frame_end_o <= 1'b0;
            dout_o      <= 1'b0;
        end else begin
            s1          <= din_i;
            s2          <= s1;
            s2_d        <= s2;
            hcnt        <= s2 ? ((hcnt == H_SAT) ? hcnt : hcnt + 1'b1) : '0;
            lcnt        <= s2 ? '0 : ((lcnt == L_RST) ? lcnt : lcnt + 1'b1);
            bitcnt      <= bitcnt_n;
            shreg       <= shreg_n;
            grb_o       <= grb_n;
            valid_o     <= valid_n;
            frame_end_o <= fe_n;
            dout_o      <= dout_n;
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Self-checking bench for ws2812_rx: pulse programs are decoded by an
// event-level reference model and compared against the observed outputs.
module tb_ws2812_rx;

    localparam int RST = 1250;
    localparam int THR = 15;
    localparam int GLT = 2;
    localparam int HN  = 65536;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        din_i = 1'b0;
    logic        dout_o;
    logic [23:0] grb_o;
    logic        valid_o;
    logic        frame_end_o;

    int checks = 0;
    int failures = 0;
    int ecount = 0;

    logic        din_hist  [HN];
    logic        dout_hist [HN];
    int          obs_v_edge[$];
    logic [23:0] obs_v_word[$];
    int          obs_fe[$];
    int          ph[$];
    int          pl[$];
    logic [23:0] last_word = '0;

    ws2812_rx #(
        .CLK_SPEED(25_000_000),
        .THRESHOLD_NS(600),
        .GLITCH_NS(100),
        .RESET_US(50)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din_i(din_i),
        .dout_o(dout_o),
        .grb_o(grb_o),
        .valid_o(valid_o),
        .frame_end_o(frame_end_o)
    );

    always #20 clk = ~clk;

    // edge k samples din_hist[k]; dout_hist[k] is the output after edge k
    always @(posedge clk) begin
        if (ecount < HN) din_hist[ecount] <= din_i;
        ecount <= ecount + 1;
    end

    always @(negedge clk) begin
        if (ecount > 0 && ecount <= HN) dout_hist[ecount-1] <= dout_o;
        if (valid_o === 1'b1) begin
            obs_v_edge.push_back(ecount - 1);
            obs_v_word.push_back(grb_o);
        end
        if (frame_end_o === 1'b1) obs_fe.push_back(ecount - 1);
    end

    task automatic clear_obs();
        obs_v_edge.delete();
        obs_v_word.delete();
        obs_fe.delete();
    endtask

    task automatic drive(input int h, input int l);
        din_i = 1'b1;
        repeat (h) @(negedge clk);
        din_i = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    task automatic add_pulse(input int h, input int l);
        ph.push_back(h);
        pl.push_back(l);
    endtask

    task automatic add_word(input logic [23:0] w, input bit rnd);
        for (int i = 23; i >= 0; i--) begin
            if (rnd) add_pulse(w[i] ? $urandom_range(25, 15) : $urandom_range(14, 2),
                               $urandom_range(30, 8));
            else     add_pulse(w[i] ? 20 : 10, w[i] ? 11 : 21);
        end
    endtask

    task automatic run_program(input string name);
        int S, t, N, nb, ws, fwd_hi, mism, hi;
        bit fwd;
        bit e;
        logic [23:0] acc;
        int ev_e[$];
        logic [23:0] ev_w[$];
        int efe[$];
        int wst[$];
        int wen[$];
        @(negedge clk);
        clear_obs();
        S = ecount;
        t = S; nb = 0; acc = '0; fwd = 0; ws = 0; fwd_hi = 0;
        for (int i = 0; i < ph.size(); i++) begin
            N = t + ph[i];
            if (fwd) begin
                fwd_hi += ph[i];
            end else if (ph[i] >= GLT) begin
                acc = acc * 2 + ((ph[i] >= THR) ? 24'd1 : 24'd0);
                nb++;
                if (nb == 24) begin
                    ev_e.push_back(N + 2);
                    ev_w.push_back(acc);
                    last_word = acc;
                    fwd = 1;
                    ws = N + 3;
                end
            end
            if (pl[i] >= RST) begin
                efe.push_back(N + RST + 1);
                if (fwd) begin
                    wst.push_back(ws);
                    wen.push_back(N + RST + 1);
                end
                fwd = 0; nb = 0; acc = '0;
            end
            t = N + pl[i];
        end
        for (int i = 0; i < ph.size(); i++) drive(ph[i], pl[i]);
        repeat (20) @(negedge clk);

        checks++;
        if (obs_v_edge.size() != ev_e.size()) begin
            failures++;
            $display("FAIL %s valid_count: got %0d expected %0d", name, obs_v_edge.size(), ev_e.size());
        end
        for (int i = 0; i < ev_e.size() && i < obs_v_edge.size(); i++) begin
            checks++;
            if (obs_v_edge[i] !== ev_e[i] || obs_v_word[i] !== ev_w[i]) begin
                failures++;
                $display("FAIL %s valid[%0d]: got edge %0d word %06h expected edge %0d word %06h",
                         name, i, obs_v_edge[i], obs_v_word[i], ev_e[i], ev_w[i]);
            end
        end
        checks++;
        if (obs_fe.size() != efe.size()) begin
            failures++;
            $display("FAIL %s frame_end_count: got %0d expected %0d", name, obs_fe.size(), efe.size());
        end
        for (int i = 0; i < efe.size() && i < obs_fe.size(); i++) begin
            checks++;
            if (obs_fe[i] !== efe[i]) begin
                failures++;
                $display("FAIL %s frame_end[%0d]: got edge %0d expected edge %0d", name, i, obs_fe[i], efe[i]);
            end
        end
        mism = 0; hi = 0;
        for (int k = S; k < ecount - 1; k++) begin
            e = 1'b0;
            for (int w = 0; w < wst.size(); w++)
                if (k >= wst[w] && k <= wen[w]) e = din_hist[k-2];
            if (dout_hist[k] !== e) mism++;
            if (dout_hist[k] === 1'b1) hi++;
        end
        checks++;
        if (mism != 0) begin
            failures++;
            $display("FAIL %s dout_trace: got %0d mismatching cycles expected 0", name, mism);
        end
        checks++;
        if (hi != fwd_hi) begin
            failures++;
            $display("FAIL %s dout_high_cycles: got %0d expected %0d", name, hi, fwd_hi);
        end
        checks++;
        if (grb_o !== last_word) begin
            failures++;
            $display("FAIL %s grb_hold: got %06h expected %06h", name, grb_o, last_word);
        end
        ph.delete();
        pl.delete();
    endtask

    task automatic check_const(input string name, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %06h expected %06h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        int R;
        reset = 1'b1;
        din_i = 1'b0;
        repeat (4) @(negedge clk);
        check_const("reset_dout", {23'd0, dout_o}, 24'd0);
        check_const("reset_grb", grb_o, 24'd0);
        check_const("reset_valid", {23'd0, valid_o}, 24'd0);
        check_const("reset_frame_end", {23'd0, frame_end_o}, 24'd0);
        clear_obs();
        reset = 1'b0;
        R = ecount;
        repeat (1400) @(negedge clk);
        checks++;
        if (obs_fe.size() != 1 || obs_fe[0] != R + 1249) begin
            failures++;
            $display("FAIL idle_frame_end: got %0d pulses first edge %0d expected 1 pulse at edge %0d",
                     obs_fe.size(), (obs_fe.size() > 0) ? obs_fe[0] : -1, R + 1249);
        end
        checks++;
        if (obs_v_edge.size() != 0) begin
            failures++;
            $display("FAIL idle_valid: got %0d pulses expected 0", obs_v_edge.size());
        end
        last_word = '0;
    endtask

    task automatic test_single_frame();
        add_word(24'hA5C33C, 0);
        pl[pl.size()-1] = 1500;
        run_program("single");
        check_const("single_word", grb_o, 24'hA5C33C);
    endtask

    task automatic test_chain();
        add_word(24'h123456, 0);
        add_word(24'hFFFF00, 0);
        pl[pl.size()-1] = 1250;
        add_word(24'h0000FF, 0);
        pl[pl.size()-1] = 1500;
        run_program("chain");
        check_const("chain_word", grb_o, 24'h0000FF);
    endtask

    task automatic test_thresholds();
        add_word(24'h5A3C96, 0);
        ph[0] = 14;
        ph[1] = 15;
        pl[5] = 1249;
        ph.insert(10, 1);
        pl.insert(10, 10);
        pl[pl.size()-1] = 1250;
        run_program("thresholds");
        check_const("thresholds_word", grb_o, 24'h5A3C96);
        add_word(24'($urandom), 1);
        pl[pl.size()-1] = 1300;
        run_program("after_exact_gap");
    endtask

    task automatic test_partial();
        logic [23:0] w;
        w = 24'h3C5A96;
        for (int i = 23; i >= 14; i--) add_pulse(w[i] ? 20 : 10, w[i] ? 11 : 21);
        pl[pl.size()-1] = 1250;
        add_word(24'h00FF00, 0);
        pl[pl.size()-1] = 1500;
        run_program("partial");
        check_const("partial_word", grb_o, 24'h00FF00);
    endtask

    task automatic test_reset_mid();
        logic [23:0] w;
        @(negedge clk);
        clear_obs();
        w = 24'h5A5A5A;
        for (int i = 23; i >= 12; i--) drive(w[i] ? 20 : 10, 10);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_const("mid_reset_outputs", grb_o | {23'd0, dout_o | valid_o | frame_end_o}, 24'd0);
        checks++;
        if (obs_v_edge.size() != 0) begin
            failures++;
            $display("FAIL mid_reset_partial_valid: got %0d pulses expected 0", obs_v_edge.size());
        end
        last_word = '0;
        reset = 1'b0;
        add_word(24'hABCDEF, 0);
        pl[pl.size()-1] = 1300;
        run_program("reset_mid");
        checks++;
        if (obs_v_edge.size() != 1) begin
            failures++;
            $display("FAIL reset_mid_single_valid: got %0d pulses expected 1", obs_v_edge.size());
        end
        check_const("reset_mid_word", grb_o, 24'hABCDEF);
    endtask

    task automatic test_random();
        int base, n;
        for (int f = 0; f < 4; f++) begin
            base = ph.size();
            add_word(24'($urandom), 1);
            n = $urandom_range(2, 0);
            for (int g = 0; g < n; g++) begin
                ph.insert(base + $urandom_range(20, 1), 1);
                pl.insert(base + $urandom_range(20, 1), $urandom_range(20, 5));
            end
            n = $urandom_range(30, 0);
            for (int x = 0; x < n; x++) add_pulse($urandom_range(25, 1), $urandom_range(30, 8));
            pl[pl.size()-1] = $urandom_range(1400, 1250);
        end
        run_program("random");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_chain();
        test_thresholds();
        test_partial();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
